read_sweep: RTL

READ_SWEEP -- requirements
Module: read_sweep

---
 rtl/read_sweep.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/read_sweep.sv
// rtl/read_sweep.sv - address sweep that issues reads, checks data against a pattern and tallies failures
module read_sweep #(
    parameter int TIMEOUT = 255,
    parameter int SETTLE  = 2
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        go_in,
    input  logic [8:0]  a_first_in,
    input  logic [8:0]  a_last_in,
    input  logic [7:0]  expect_in,
    input  logic [1:0]  pat_mode_in,
    output logic        rc_start_out,
    output logic [8:0]  rc_a_out,
    input  logic        rc_reading_in,
    input  logic [7:0]  rc_q_in,
    output logic        res_valid_out,
    output logic [8:0]  res_addr_out,
    output logic [7:0]  res_data_out,
    output logic        res_fail_out,
    output logic [15:0] err_count_out,
    output logic [8:0]  first_fail_addr_out,
    output logic [7:0]  first_fail_data_out,
    output logic        fail_seen_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        timeout_out
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_SETTLE    = 3'd4;
    localparam logic [2:0] ST_CHECK     = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    logic [2:0]  state;
    logic [8:0]  addr;
    logic [8:0]  a_last;
    logic [7:0]  expect_r;
    logic [1:0]  mode;
    logic [15:0] cnt;
    logic [16:0] cnt_inc;
    logic [7:0]  exp_byte;

    assign cnt_inc = {1'b0, cnt} + 17'd1;

    always_comb begin
        exp_byte = expect_r;
        case (mode)
            2'b00: exp_byte = expect_r;
            2'b01: exp_byte = addr[7:0];
            2'b10: exp_byte = addr[7:0] ^ expect_r;
            2'b11: exp_byte = ~expect_r;
            default: exp_byte = expect_r;
        endcase
    end

    // Outputs that are pure state decodes; IDLE is the reset state so they reset cleanly.
    assign rc_start_out  = (state == ST_ISSUE);
    assign rc_a_out      = (state == ST_IDLE || state == ST_DONE) ? 9'h1FF : addr;
    assign res_valid_out = (state == ST_CHECK);
    assign busy_out      = !(state == ST_IDLE || state == ST_DONE);
    assign done_out      = (state == ST_DONE);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state               <= ST_IDLE;
            addr                <= 9'd0;
            a_last              <= 9'd0;
            expect_r            <= 8'd0;
            mode                <= 2'd0;
            cnt                 <= 16'd0;
            res_addr_out        <= 9'd0;
            res_data_out        <= 8'd0;
            res_fail_out        <= 1'b0;
            err_count_out       <= 16'd0;
            first_fail_addr_out <= 9'd0;
            first_fail_data_out <= 8'd0;
            fail_seen_out       <= 1'b0;
            timeout_out         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (go_in) begin
                        addr                <= a_first_in;
                        a_last              <= a_last_in;
                        expect_r            <= expect_in;
                        mode                <= pat_mode_in;
                        err_count_out       <= 16'd0;
                        first_fail_addr_out <= 9'd0;
                        first_fail_data_out <= 8'd0;
                        fail_seen_out       <= 1'b0;
                        timeout_out         <= 1'b0;
                        state               <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= 16'd0;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (rc_reading_in) begin
                        cnt   <= 16'd0;
                        state <= ST_WAIT_DONE;
                    end else if (cnt_inc >= 17'(TIMEOUT)) begin
                        // A read that never starts is reported as a failing 0xFF result.
                        timeout_out  <= 1'b1;
                        res_addr_out <= addr;
                        res_data_out <= 8'hFF;
                        res_fail_out <= 1'b1;
                        state        <= ST_CHECK;
                    end else begin
                        cnt <= cnt_inc[15:0];
                    end
                end
                ST_WAIT_DONE: begin
                    if (!rc_reading_in) begin
                        cnt   <= 16'd0;
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if ({1'b0, cnt} >= 17'(SETTLE)) begin
                        res_addr_out <= addr;
                        res_data_out <= rc_q_in;
                        res_fail_out <= (rc_q_in != exp_byte);
                        state        <= ST_CHECK;
                    end else begin
                        cnt <= cnt_inc[15:0];
                    end
                end
                ST_CHECK: begin
                    if (res_fail_out) begin
                        if (err_count_out != 16'hFFFF)
                            err_count_out <= err_count_out + 16'd1;
                        if (!fail_seen_out) begin
                            first_fail_addr_out <= res_addr_out;
                            first_fail_data_out <= res_data_out;
                            fail_seen_out       <= 1'b1;
                        end
                    end
                    if (addr == a_last) begin
                        state <= ST_DONE;
                    end else begin
                        addr  <= addr + 9'd1;
                        state <= ST_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
